// File: rtl/alu_regfile_psr.sv
// Register file and masked processor status register sitting downstream of the ALU.
// Optional write-through forwarding on both read ports and c_in: define ALU_REGFILE_BYPASS_EN.
module alu_regfile_psr #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] SRC,
  output logic [DATA_W-1:0] DST,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] C,
  input  logic [FLAG_W-1:0] Flags,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              psr_wr_en,
  input  logic [FLAG_W-1:0] psr_wdata,
  output logic [FLAG_W-1:0] PSR,
  output logic              c_in,
  output logic [15:0]       wr_count
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 16;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [FLAG_W-1:0] psr_q, psr_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  // Next-state: write-back, masked PSR merge (AND-OR keeps masked-off X bits out), saturating count
  always_comb begin
    regs_d     = regs_q;
    psr_d      = psr_q;
    wr_count_d = wr_count_q;
    if (wr_en) begin
      regs_d[dst_addr] = C;
      if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + CNT_W'(1);
    end
    if (psr_wr_en) psr_d = psr_wdata;
    else           psr_d = (Flags & flag_mask) | (psr_q & ~flag_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      psr_q      <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      psr_q      <= psr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports and carry-in
  always_comb begin
    SRC  = regs_q[src_addr];
    DST  = regs_q[dst_addr];
    c_in = psr_q[0];
`ifdef ALU_REGFILE_BYPASS_EN
    if (wr_en && (src_addr == dst_addr)) SRC = C;
    if (wr_en) DST = C;
    if (psr_wr_en)         c_in = psr_wdata[0];
    else if (flag_mask[0]) c_in = Flags[0];
`endif
  end

  assign PSR      = psr_q;
  assign wr_count = wr_count_q;

endmodule

// File: doc/alu_regfile_psr.md
Name: alu_regfile_psr

Overview:
- Register file and processor status register (PSR) directly downstream of the ALU wrapper.
- Captures the ALU result C and Flags[4:0] on the clock edge.
- Drives the next operation's SRC and DST operands from two read ports, and drives c_in from the stored carry flag.
- 16 general registers x 16 bits, plus a 5-bit PSR with per-bit update mask.

Parameters:
- DATA_W, 16, register and operand width
- ADDR_W, 4, register address width (2**ADDR_W registers)
- FLAG_W, 5, PSR width; bit map [0]=C carry, [1]=L unsigned-low, [2]=F overflow, [3]=N negative, [4]=Z zero

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- src_addr  in  ADDR_W  read port A address
- dst_addr  in  ADDR_W  read port B address, also the write-back address
- SRC  out  DATA_W  contents of regs[src_addr], to ALU SRC
- DST  out  DATA_W  contents of regs[dst_addr], to ALU DST
- wr_en  in  1  write C into regs[dst_addr] this edge
- C  in  DATA_W  ALU result
- Flags  in  FLAG_W  ALU flags for current operation
- flag_mask  in  FLAG_W  per-bit PSR update enable (1 = load Flags[i])
- psr_wr_en  in  1  direct PSR load from psr_wdata (LPR-style), overrides flag_mask
- psr_wdata  in  FLAG_W  direct PSR load value
- PSR  out  FLAG_W  registered status flags
- c_in  out  1  PSR[0], to ALU carry-in
- wr_count  out  16  saturating count of committed register writes (debug)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. No asynchronous reset path.
- Reset, on the edge with reset=1:
  - all 16 registers = 0, PSR = 0, wr_count = 0
  - all writes that cycle are suppressed
  - SRC, DST, PSR, c_in all read 0 after that edge
- Read ports:
  - combinational from the register array; zero latency from address change
  - both ports may address the same register
- Write:
  - wr_en=1 at an edge stores C into regs[dst_addr]
  - visible on SRC/DST from the following cycle; without the bypass this is one-cycle latency
  - every register, including r0, is writable (no hardwired zero)
- PSR update, per edge, in priority order:
  1. reset
  2. psr_wr_en: PSR <= psr_wdata
  3. otherwise, for each bit i: PSR[i] <= flag_mask[i] ? Flags[i] : PSR[i]
- Flag usage:
  - compare operations drive wr_en=0 with a nonzero flag_mask; PSR changes, no register is written
  - logical operations typically mask only Z and N; other PSR bits hold
- wr_count:
  - increments by 1 on each edge with wr_en=1 and reset=0
  - saturates at 16'hFFFF and does not wrap
- Simultaneous events:
  - wr_en together with psr_wr_en: both take effect, independent state
  - reset together with wr_en: reset wins, no write, count stays 0
- No X propagation:
  - undriven Flags bits masked off by flag_mask=0 must not corrupt PSR
  - SRC='x' from the bench has no effect on state

Optional Feature:
- Macro: ALU_REGFILE_BYPASS_EN
- Defined:
  - write-through forwarding; when wr_en=1 and src_addr or dst_addr equals the write address, that port outputs C combinationally in the same cycle
  - c_in = flag_mask[0] ? Flags[0] : PSR[0], or psr_wdata[0] when psr_wr_en
- Undefined:
  - ports always show the pre-edge register contents
  - c_in = PSR[0] strictly

Test Plan:
- Reset and clear: write 16'h1234 to r3, assert reset 1 cycle -> SRC=DST=0 for all addresses, PSR=5'b0, wr_count=0.
- Write/read latency: wr_en=1, dst_addr=5, C=16'hBEEF -> DST=16'hBEEF the next cycle (same cycle only with BYPASS_EN); SRC at src_addr=5 matches.
- Masked flags, compare: wr_en=0, Flags=5'b10101, flag_mask=5'b11111 -> PSR=5'b10101, c_in=1, no register changed, wr_count unchanged.
  - Then Flags=5'b01010, flag_mask=5'b11000 -> PSR=5'b01101.
- Unsigned add carry chain: PSR[0] set by add 16'hFFFF+1 (C=0, Flags Z|C) -> stored r1=0, c_in=1 next cycle, PSR[4]=1.
- Priority and simultaneity: psr_wr_en=1, psr_wdata=5'b00100, flag_mask=5'b11111, Flags=5'b11011, wr_en=1 to r7 -> PSR=5'b00100, r7 written.
  - Same cycle with reset=1 -> nothing written, all zero.
- Counter saturation: force 65536 writes -> wr_count holds 16'hFFFF and does not wrap to 0.
